// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if -- signal bundle between the PLL reset sequencer and its user.
//   pll_lock  PLL lock flag, asynchronous to the block clock (user -> sequencer)
//   rst_out   core reset, active-high (sequencer -> user)
//   ready     high only while the sequencer is in RUN
//   loss_cnt  saturating count of lock-loss events
//   state_o   sequencer state: 0 HOLD, 1 WAIT, 2 RUN, 3 LOST
interface pll_rst_seq_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             rst_out;
    logic             ready;
    logic [CNT_W-1:0] loss_cnt;
    logic [1:0]       state_o;

    // master drives the lock flag and observes the sequencer
    modport master (output pll_lock, input rst_out, ready, loss_cnt, state_o);
    // slave is the sequencer itself
    modport slave  (input pll_lock, output rst_out, ready, loss_cnt, state_o);
endinterface

// File: rtl/pll_rst_seq.sv
// pll_rst_seq -- reset sequencer running on the PLL output clock.
// Holds the core in reset until the synchronised lock flag has been high for
// STABLE_CYCLES consecutive cycles, releases a synchronously deasserted reset,
// and re-enters reset (counting the event) when lock drops for LOSS_FILTER
// consecutive cycles while running.
//   clki  PLL output clock (block clock)
//   rst   asynchronous reset, active-high
//   bus   pll_rst_seq_if.slave: pll_lock in; rst_out, ready, loss_cnt, state_o out
module pll_rst_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int RST_HOLD      = 16,
    parameter int LOSS_FILTER   = 4,
    parameter int CNT_W         = 8
) (
    input  logic         clki,
    input  logic         rst,
    pll_rst_seq_if.slave bus
);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int LW = $clog2(LOSS_FILTER + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] LOW_LAST  = LW'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {HOLD = 2'd0, WAIT = 2'd1, RUN = 2'd2, LOST = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      stab_q, stab_d;
    logic [LW-1:0]      low_q, low_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               rst_out_q, ready_q;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic               lock_s;
    logic               rst_ok;

    // lock_sync brings pll_lock into the clki domain. rst_sync samples the
    // falling edge of rst on clki: the FSM stays parked at the start of HOLD
    // until a 1 has walked through it, so the release latency is
    // SYNC_STAGES + RST_HOLD + STABLE_CYCLES from rst deassertion.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
            rst_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_lock};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign rst_ok = rst_sync[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stab_d  = stab_q;
        low_d   = low_q;
        loss_d  = loss_q;
        case (state_q)
            HOLD: begin
                if (rst_ok) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = WAIT;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                // any low sample restarts the stability window
                if (!lock_s) begin
                    stab_d = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RUN: begin
                if (lock_s) begin
                    low_d = '0;
                end else if (low_q == LOW_LAST) begin
                    state_d = LOST;
                    low_d   = '0;
                    if (loss_q != {CNT_W{1'b1}})
                        loss_d = loss_q + 1'b1;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            LOST: begin
                state_d = HOLD;
                hold_d  = '0;
                stab_d  = '0;
                low_d   = '0;
            end
            default: state_d = HOLD;
        endcase
    end

    // rst_out/ready are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            stab_q    <= '0;
            low_q     <= '0;
            loss_q    <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stab_q    <= stab_d;
            low_q     <= low_d;
            loss_q    <= loss_d;
            rst_out_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign bus.rst_out  = rst_out_q;
    assign bus.ready    = ready_q;
    assign bus.loss_cnt = loss_q;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq -- directed bench for pll_rst_seq with SYNC=2, STABLE=8,
// HOLD=4, FILTER=4, CNT_W=2. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point.
module tb_pll_rst_seq;
    logic clki = 1'b0;
    logic rst  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pll_rst_seq_if #(.CNT_W(2)) bus ();

    pll_rst_seq #(
        .SYNC_STAGES(2), .STABLE_CYCLES(8), .RST_HOLD(4), .LOSS_FILTER(4), .CNT_W(2)
    ) dut (
        .clki(clki),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clki = ~clki;

    task automatic tick;
        @(posedge clki);
        #1;
    endtask

    // async assert, check reset outputs, then release just after an edge
    task automatic test_reset(input logic lock);
        rst = 1'b1;
        bus.pll_lock = lock;
        tick();
        tick();
        checks++; if (bus.rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out got=%b exp=1", bus.rst_out); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.loss_cnt !== 2'd0) begin errors++; $display("FAIL reset_loss_cnt got=%0d exp=0", bus.loss_cnt); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
        rst = 1'b0;
    endtask

    // rst just released with pll_lock high: WAIT entered on edge 6,
    // RUN / rst_out low / ready high on edge 14
    task automatic test_release;
        int s1 = -1, s2 = -1, r0 = -1, rd = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (s1 < 0 && bus.state_o == 2'd1) s1 = n;
            if (s2 < 0 && bus.state_o == 2'd2) s2 = n;
            if (r0 < 0 && bus.rst_out == 1'b0) r0 = n;
            if (rd < 0 && bus.ready == 1'b1) rd = n;
        end
        checks++; if (s1 !== 6) begin errors++; $display("FAIL release_wait_edge got=%0d exp=6", s1); end
        checks++; if (s2 !== 14) begin errors++; $display("FAIL release_run_edge got=%0d exp=14", s2); end
        checks++; if (r0 !== 14) begin errors++; $display("FAIL release_rst_out_edge got=%0d exp=14", r0); end
        checks++; if (rd !== 14) begin errors++; $display("FAIL release_ready_edge got=%0d exp=14", rd); end
        checks++; if (bus.loss_cnt !== 2'd0) begin errors++; $display("FAIL release_loss_cnt got=%0d exp=0", bus.loss_cnt); end
    endtask

    // 5-cycle lock pulse in WAIT must not release; later steady lock
    // releases on the 10th edge after pll_lock rises (8 after lock_s)
    task automatic test_wait_glitch;
        int bad = 0;
        int rel = -1;
        test_reset(1'b0);
        repeat (10) tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL wait_parked_state got=%0d exp=1", bus.state_o); end
        bus.pll_lock = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (bus.rst_out !== 1'b1 || bus.state_o !== 2'd1) bad++;
        end
        bus.pll_lock = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.rst_out !== 1'b1 || bus.state_o !== 2'd1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wait_pulse_no_release bad_cycles=%0d exp=0", bad); end
        bus.pll_lock = 1'b1;
        for (int n = 1; n <= 20 && rel < 0; n++) begin
            tick();
            if (bus.rst_out == 1'b0) rel = n;
        end
        checks++; if (rel !== 10) begin errors++; $display("FAIL wait_restart_release_edge got=%0d exp=10", rel); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL wait_restart_ready got=%b exp=1", bus.ready); end
    endtask

    // 3-cycle low in RUN is filtered out
    task automatic test_run_glitch;
        int bad = 0;
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        bus.pll_lock = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (bus.ready !== 1'b1 || bus.state_o !== 2'd2) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL run_glitch_ready bad_cycles=%0d exp=0", bad); end
        checks++; if (bus.loss_cnt !== 2'd0) begin errors++; $display("FAIL run_glitch_loss_cnt got=%0d exp=0", bus.loss_cnt); end
    endtask

    // from RUN: lock low -> LOST on edge 6, HOLD next, RUN 13 edges after LOST
    task automatic force_loss(input int exp_cnt, input int idx);
        int lost = -1;
        int rel = -1;
        bus.pll_lock = 1'b0;
        for (int n = 1; n <= 20 && lost < 0; n++) begin
            tick();
            if (bus.state_o == 2'd3) lost = n;
        end
        bus.pll_lock = 1'b1;
        checks++; if (lost !== 6) begin errors++; $display("FAIL loss%0d_lost_edge got=%0d exp=6", idx, lost); end
        checks++; if (bus.rst_out !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL loss%0d_outputs rst_out=%b ready=%b exp=1/0", idx, bus.rst_out, bus.ready); end
        checks++; if (bus.loss_cnt !== 2'(exp_cnt)) begin errors++; $display("FAIL loss%0d_loss_cnt got=%0d exp=%0d", idx, bus.loss_cnt, exp_cnt); end
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL loss%0d_to_hold got=%0d exp=0", idx, bus.state_o); end
        for (int n = 2; n <= 30 && rel < 0; n++) begin
            tick();
            if (bus.ready == 1'b1) rel = n;
        end
        checks++; if (rel !== 13) begin errors++; $display("FAIL loss%0d_rerelease_edge got=%0d exp=13", idx, rel); end
    endtask

    task automatic test_lock_loss;
        force_loss(1, 0);
    endtask

    task automatic test_saturation;
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        test_reset(1'b1);
        test_release();
        for (int i = 0; i < 5; i++) force_loss(exp_cnt[i], i + 1);
    endtask

    // rst between edges while in RUN with loss_cnt=3
    task automatic test_async_rst;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.rst_out !== 1'b1) begin errors++; $display("FAIL async_rst_out got=%b exp=1", bus.rst_out); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL async_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.loss_cnt !== 2'd0) begin errors++; $display("FAIL async_loss_cnt got=%0d exp=0", bus.loss_cnt); end
        tick();
        rst = 1'b0;
        test_release();
    endtask

    task automatic test_toggle;
        int bad = 0;
        test_reset(1'b0);
        for (int n = 0; n < 100; n++) begin
            bus.pll_lock = ~bus.pll_lock;
            tick();
            if (bus.rst_out !== 1'b1 || bus.state_o == 2'd2 || bus.ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_no_release bad_cycles=%0d exp=0", bad); end
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL toggle_state got=%0d exp=1", bus.state_o); end
    endtask

    initial begin
        bus.pll_lock = 1'b1;
        tick();
        test_reset(1'b1);
        test_release();
        test_run_glitch();
        test_lock_loss();
        test_wait_glitch();
        test_saturation();
        test_async_rst();
        test_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
